// File: rtl/disp_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_sched_pkg
//  Description : Shared character, source and state encodings for the
//                display scheduler and its window selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_sched_pkg;

    localparam int CHAR_W     = 6;
    localparam int UNIT_BCD_W = 6;
    localparam int DIGITS     = UNIT_BCD_W;
    localparam int MAX_CHARS  = 16;

    localparam logic [CHAR_W-1:0] CHAR_BLANK = 6'h24;

    localparam logic [1:0] SRC_MENU  = 2'b00;
    localparam logic [1:0] SRC_MORSE = 2'b01;
    localparam logic [1:0] SRC_MSG   = 2'b10;

    typedef enum logic [1:0] {
        ST_SHOW   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_MSG    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/disp_sched_window_sel.sv
`default_nettype none
// ============================================================================
//  Module      : disp_window_sel
//  Description : Picks DIGITS consecutive chars of a word starting at offset;
//                positions past the end of the word show a blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_window_sel #(
    parameter int CHAR_W    = disp_sched_pkg::CHAR_W,
    parameter int DIGITS    = disp_sched_pkg::DIGITS,
    parameter int MAX_CHARS = disp_sched_pkg::MAX_CHARS,
    parameter int OFF_W     = $clog2(MAX_CHARS)
) (
    input  logic [MAX_CHARS*CHAR_W-1:0] word,
    input  logic [OFF_W-1:0]            offset,
    output logic [DIGITS*CHAR_W-1:0]    win
);
    import disp_sched_pkg::*;

    localparam int c_idx_w = $clog2(MAX_CHARS + DIGITS);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [c_idx_w-1:0] w_idx;
            logic [CHAR_W-1:0]  w_char;

            always_comb begin
                w_idx = c_idx_w'(offset) + c_idx_w'(gi);
                if (w_idx < c_idx_w'(MAX_CHARS))
                    w_char = word[w_idx*CHAR_W +: CHAR_W];
                else
                    w_char = CHAR_W'(CHAR_BLANK);
            end

            assign win[gi*CHAR_W +: CHAR_W] = w_char;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/disp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : disp_sched
//  Description : Shares the six display digits between MENU, the decoded
//                Morse word (scrolled when too long) and one-shot messages.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_sched #(
    parameter int CHAR_W      = disp_sched_pkg::CHAR_W,
    parameter int DIGITS      = disp_sched_pkg::DIGITS,
    parameter int MAX_CHARS   = disp_sched_pkg::MAX_CHARS,
    parameter int MSG_TICKS   = 8,
    parameter int PAUSE_TICKS = 4
) (
    input  logic                             clk,
    input  logic                             sclr,
    input  logic                             ce,
    input  logic                             tick,
    input  logic                             mode_morse,
    input  logic [DIGITS*CHAR_W-1:0]         menu_word,
    input  logic [DIGITS-1:0]                menu_blink,
    input  logic [MAX_CHARS*CHAR_W-1:0]      word,
    input  logic [$clog2(MAX_CHARS+1)-1:0]   word_len,
    input  logic                             word_ended,
    input  logic                             msg_req,
    input  logic [DIGITS*CHAR_W-1:0]         msg_word,
    output logic                             msg_ack,
    output logic [DIGITS*CHAR_W-1:0]         disp_word,
    output logic [DIGITS-1:0]                disp_blink,
    output logic [1:0]                       src,
    output logic                             scrolling
);
    import disp_sched_pkg::*;

    localparam int c_len_w     = $clog2(MAX_CHARS + 1);
    localparam int c_off_w     = $clog2(MAX_CHARS);
    localparam int c_msg_lim   = (MSG_TICKS < 1) ? 1 : MSG_TICKS;
    localparam int c_pause_lim = (PAUSE_TICKS < 1) ? 1 : PAUSE_TICKS;
    localparam int c_tick_max  = (c_msg_lim > c_pause_lim) ? c_msg_lim : c_pause_lim;
    localparam int c_tcnt_w    = $clog2(c_tick_max + 1);
    localparam logic [DIGITS*CHAR_W-1:0] c_blank_word = {DIGITS{CHAR_W'(CHAR_BLANK)}};

    state_t                     r_state, w_nxt_state;
    logic [c_off_w-1:0]         r_offset, w_nxt_offset;
    logic [c_tcnt_w-1:0]        r_tcnt, w_nxt_tcnt;
    logic [DIGITS*CHAR_W-1:0]   r_msg, w_nxt_msg;
    logic [c_len_w-1:0]         r_scroll_len;
    logic [DIGITS*CHAR_W-1:0]   r_disp_word;
    logic [DIGITS-1:0]          r_disp_blink;
    logic [1:0]                 r_src;
    logic                       r_ack;
    logic                       r_scrolling;

    logic [c_len_w-1:0]         w_len;
    logic                       w_long;
    logic [c_off_w-1:0]         w_reload;
    logic                       w_accept;
    logic                       w_exit;
    logic [DIGITS*CHAR_W-1:0]   w_win;

    assign w_len    = (word_len > c_len_w'(MAX_CHARS)) ? c_len_w'(MAX_CHARS) : word_len;
    assign w_long   = (w_len > c_len_w'(DIGITS));
    assign w_reload = w_long ? c_off_w'(w_len - c_len_w'(DIGITS)) : '0;
    assign w_accept = msg_req && (r_state != ST_MSG);
    // r_scroll_len tracks word_len while in SHOW, so it holds the entry length
    assign w_exit   = !word_ended || !mode_morse || (word_len != r_scroll_len);

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_offset = r_offset;
        w_nxt_tcnt   = r_tcnt;
        w_nxt_msg    = r_msg;
        if (w_accept) begin
            w_nxt_state  = ST_MSG;
            w_nxt_offset = '0;
            w_nxt_tcnt   = '0;
            w_nxt_msg    = msg_word;
        end else begin
            case (r_state)
                ST_SHOW: begin
                    if (mode_morse && word_ended && w_long) begin
                        w_nxt_state  = ST_SCROLL;
                        w_nxt_offset = w_reload;
                    end
                end
                ST_SCROLL: begin
                    if (w_exit) begin
                        w_nxt_state  = ST_SHOW;
                        w_nxt_offset = '0;
                    end else if (tick) begin
                        if (r_offset == '0) begin
                            w_nxt_state = ST_PAUSE;
                            w_nxt_tcnt  = '0;
                        end else begin
                            w_nxt_offset = r_offset - c_off_w'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_exit) begin
                        w_nxt_state  = ST_SHOW;
                        w_nxt_offset = '0;
                    end else if (tick) begin
                        if (r_tcnt >= c_tcnt_w'(c_pause_lim - 1)) begin
                            w_nxt_state  = ST_SCROLL;
                            w_nxt_offset = w_reload;
                            w_nxt_tcnt   = '0;
                        end else begin
                            w_nxt_tcnt = r_tcnt + c_tcnt_w'(1);
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (r_tcnt >= c_tcnt_w'(c_msg_lim - 1)) begin
                            w_nxt_state  = ST_SHOW;
                            w_nxt_offset = '0;
                            w_nxt_tcnt   = '0;
                        end else begin
                            w_nxt_tcnt = r_tcnt + c_tcnt_w'(1);
                        end
                    end
                end
            endcase
        end
    end

    disp_window_sel #(
        .CHAR_W    (CHAR_W),
        .DIGITS    (DIGITS),
        .MAX_CHARS (MAX_CHARS),
        .OFF_W     (c_off_w)
    ) u_window (
        .word   (word),
        .offset (w_nxt_offset),
        .win    (w_win)
    );

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_state      <= ST_SHOW;
            r_offset     <= '0;
            r_tcnt       <= '0;
            r_msg        <= c_blank_word;
            r_scroll_len <= '0;
            r_disp_word  <= c_blank_word;
            r_disp_blink <= '0;
            r_src        <= SRC_MENU;
            r_ack        <= 1'b0;
            r_scrolling  <= 1'b0;
        end else if (ce) begin
            r_state  <= w_nxt_state;
            r_offset <= w_nxt_offset;
            r_tcnt   <= w_nxt_tcnt;
            r_msg    <= w_nxt_msg;
            r_ack    <= w_accept;
            if (r_state == ST_SHOW)
                r_scroll_len <= word_len;
            // outputs follow the state being entered, giving one cycle of latency
            case (w_nxt_state)
                ST_MSG: begin
                    r_disp_word  <= w_nxt_msg;
                    r_disp_blink <= '0;
                    r_src        <= SRC_MSG;
                    r_scrolling  <= 1'b0;
                end
                ST_SHOW: begin
                    r_scrolling <= 1'b0;
                    if (mode_morse) begin
                        r_disp_word  <= w_win;
                        r_disp_blink <= '0;
                        r_src        <= SRC_MORSE;
                    end else begin
                        r_disp_word  <= menu_word;
                        r_disp_blink <= menu_blink;
                        r_src        <= SRC_MENU;
                    end
                end
                default: begin
                    r_disp_word  <= w_win;
                    r_disp_blink <= '0;
                    r_src        <= SRC_MORSE;
                    r_scrolling  <= 1'b1;
                end
            endcase
        end
    end

    assign msg_ack    = r_ack;
    assign disp_word  = r_disp_word;
    assign disp_blink = r_disp_blink;
    assign src        = r_src;
    assign scrolling  = r_scrolling;

endmodule
`default_nettype wire

// File: tb/tb_disp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_sched
//  Description : Directed self-checking bench for disp_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_sched;
    import disp_sched_pkg::*;

    logic        clk = 1'b0;
    logic        sclr, ce, tick, mode_morse, word_ended, msg_req;
    logic [35:0] menu_word, msg_word;
    logic [5:0]  menu_blink;
    logic [95:0] word;
    logic [4:0]  word_len;

    logic        msg_ack, scrolling, msg_ack0, scrolling0;
    logic [35:0] disp_word, disp_word0;
    logic [5:0]  disp_blink, disp_blink0;
    logic [1:0]  src, src0;

    int checks = 0;
    int errors = 0;

    localparam logic [35:0] W_MENU = 36'h123456789;
    localparam logic [35:0] W_MSG  = 36'hABCDEF012;
    localparam logic [35:0] BLANKS = {6{6'h24}};

    always #5 clk = ~clk;

    disp_sched dut (
        .clk(clk), .sclr(sclr), .ce(ce), .tick(tick), .mode_morse(mode_morse),
        .menu_word(menu_word), .menu_blink(menu_blink), .word(word), .word_len(word_len),
        .word_ended(word_ended), .msg_req(msg_req), .msg_word(msg_word), .msg_ack(msg_ack),
        .disp_word(disp_word), .disp_blink(disp_blink), .src(src), .scrolling(scrolling)
    );

    disp_sched #(.MSG_TICKS(0)) dut0 (
        .clk(clk), .sclr(sclr), .ce(ce), .tick(tick), .mode_morse(mode_morse),
        .menu_word(menu_word), .menu_blink(menu_blink), .word(word), .word_len(word_len),
        .word_ended(word_ended), .msg_req(msg_req), .msg_word(msg_word), .msg_ack(msg_ack0),
        .disp_word(disp_word0), .disp_blink(disp_blink0), .src(src0), .scrolling(scrolling0)
    );

    function automatic logic [95:0] build_word(input int len);
        logic [95:0] w;
        for (int k = 0; k < 16; k++) w[k*6 +: 6] = (k < len) ? 6'(k + 1) : CHAR_BLANK;
        return w;
    endfunction

    function automatic logic [35:0] exp_win(input logic [95:0] w, input int off);
        logic [35:0] r;
        for (int i = 0; i < 6; i++) r[i*6 +: 6] = (off + i < 16) ? w[((off + i) % 16)*6 +: 6] : CHAR_BLANK;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        checks++; if (disp_word !== BLANKS) begin errors++; $display("FAIL reset_disp got %h exp %h", disp_word, BLANKS); end
        checks++; if (disp_blink !== 6'd0) begin errors++; $display("FAIL reset_blink got %b exp 000000", disp_blink); end
        checks++; if (src !== 2'b00) begin errors++; $display("FAIL reset_src got %b exp 00", src); end
        checks++; if (msg_ack !== 1'b0 || scrolling !== 1'b0) begin errors++; $display("FAIL reset_flags got ack %b scr %b exp 0 0", msg_ack, scrolling); end
    endtask

    task automatic test_menu();
        mode_morse = 1'b0; menu_word = W_MENU; menu_blink = 6'b000011;
        step();
        checks++; if (disp_word !== W_MENU) begin errors++; $display("FAIL menu_disp got %h exp %h", disp_word, W_MENU); end
        checks++; if (disp_blink !== 6'b000011) begin errors++; $display("FAIL menu_blink got %b exp 000011", disp_blink); end
        checks++; if (src !== 2'b00 || msg_ack !== 1'b0) begin errors++; $display("FAIL menu_src got src %b ack %b exp 00 0", src, msg_ack); end
    endtask

    task automatic test_short_word();
        logic [95:0] w4;
        logic [35:0] e;
        w4 = build_word(4);
        mode_morse = 1'b1; word = w4; word_len = 5'd4; word_ended = 1'b1;
        step();
        e = {CHAR_BLANK, CHAR_BLANK, 6'd4, 6'd3, 6'd2, 6'd1};
        checks++; if (disp_word !== e) begin errors++; $display("FAIL short_disp got %h exp %h", disp_word, e); end
        checks++; if (src !== 2'b01 || disp_blink !== 6'd0) begin errors++; $display("FAIL short_src got src %b blink %b exp 01 0", src, disp_blink); end
        for (int t = 0; t < 5; t++) begin
            tick_pulse();
            step();
            checks++; if (scrolling !== 1'b0) begin errors++; $display("FAIL short_noscroll tick %0d got %b exp 0", t, scrolling); end
        end
    endtask

    task automatic test_scroll();
        logic [95:0] w9;
        int exp_off [9] = '{2, 1, 0, 0, 0, 0, 0, 3, 2};
        w9 = build_word(9);
        word = w9; word_len = 5'd9; word_ended = 1'b1;
        step();
        checks++; if (disp_word !== exp_win(w9, 3) || scrolling !== 1'b1) begin errors++; $display("FAIL scroll_entry got %h scr %b exp %h 1", disp_word, scrolling, exp_win(w9, 3)); end
        for (int t = 0; t < 9; t++) begin
            tick_pulse();
            checks++; if (disp_word !== exp_win(w9, exp_off[t]) || scrolling !== 1'b1) begin errors++; $display("FAIL scroll_tick%0d got %h scr %b exp %h 1", t, disp_word, scrolling, exp_win(w9, exp_off[t])); end
            step();
        end
        word_ended = 1'b0; tick = 1'b1;
        step();
        tick = 1'b0;
        checks++; if (disp_word !== exp_win(w9, 0) || scrolling !== 1'b0 || src !== 2'b01) begin errors++; $display("FAIL scroll_exit got %h scr %b src %b exp %h 0 01", disp_word, scrolling, src, exp_win(w9, 0)); end
    endtask

    task automatic test_msg();
        logic [95:0] w9;
        w9 = build_word(9);
        word_ended = 1'b1;
        step();
        tick_pulse();
        checks++; if (disp_word !== exp_win(w9, 2)) begin errors++; $display("FAIL msg_pre got %h exp %h", disp_word, exp_win(w9, 2)); end
        msg_word = W_MSG; msg_req = 1'b1; tick = 1'b1;
        step();
        msg_req = 1'b0; tick = 1'b0;
        checks++; if (msg_ack !== 1'b1 || src !== 2'b10) begin errors++; $display("FAIL msg_accept got ack %b src %b exp 1 10", msg_ack, src); end
        checks++; if (disp_word !== W_MSG || disp_blink !== 6'd0 || scrolling !== 1'b0) begin errors++; $display("FAIL msg_disp got %h blink %b scr %b exp %h 0 0", disp_word, disp_blink, scrolling, W_MSG); end
        step();
        checks++; if (msg_ack !== 1'b0 || src !== 2'b10) begin errors++; $display("FAIL msg_ack_pulse got ack %b src %b exp 0 10", msg_ack, src); end
        for (int t = 1; t < 8; t++) begin
            if (t == 3) msg_req = 1'b1;
            tick_pulse();
            msg_req = 1'b0;
            step();
            checks++; if (src !== 2'b10 || msg_ack !== 1'b0) begin errors++; $display("FAIL msg_hold tick%0d got src %b ack %b exp 10 0", t, src, msg_ack); end
        end
        tick_pulse();
        checks++; if (src !== 2'b01 || scrolling !== 1'b0 || disp_word !== exp_win(w9, 0)) begin errors++; $display("FAIL msg_end got src %b scr %b %h exp 01 0 %h", src, scrolling, disp_word, exp_win(w9, 0)); end
    endtask

    task automatic test_msg_zero_ticks();
        sclr = 1'b1;
        step();
        sclr = 1'b0; mode_morse = 1'b0; word_ended = 1'b0; msg_req = 1'b1;
        step();
        msg_req = 1'b0;
        checks++; if (src0 !== 2'b10 || msg_ack0 !== 1'b1) begin errors++; $display("FAIL msg0_accept got src %b ack %b exp 10 1", src0, msg_ack0); end
        step();
        checks++; if (src0 !== 2'b10) begin errors++; $display("FAIL msg0_hold got %b exp 10", src0); end
        tick_pulse();
        checks++; if (src0 !== 2'b00 || disp_word0 !== W_MENU) begin errors++; $display("FAIL msg0_end got src %b %h exp 00 %h", src0, disp_word0, W_MENU); end
        checks++; if (src !== 2'b10) begin errors++; $display("FAIL msg8_still got %b exp 10", src); end
    endtask

    task automatic test_clamp_and_ce();
        logic [95:0] w16;
        w16 = build_word(16);
        sclr = 1'b1;
        step();
        sclr = 1'b0; mode_morse = 1'b1; word_ended = 1'b1; word = w16; word_len = 5'd20;
        step();
        checks++; if (disp_word !== exp_win(w16, 10) || scrolling !== 1'b1) begin errors++; $display("FAIL clamp_off got %h scr %b exp %h 1", disp_word, scrolling, exp_win(w16, 10)); end
        ce = 1'b0; tick = 1'b1; msg_req = 1'b1; menu_word = 36'h0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (c % 20 == 19) begin
                checks++; if (disp_word !== exp_win(w16, 10) || src !== 2'b01 || msg_ack !== 1'b0 || scrolling !== 1'b1) begin errors++; $display("FAIL ce_hold cyc%0d got %h src %b ack %b scr %b exp %h 01 0 1", c, disp_word, src, msg_ack, scrolling, exp_win(w16, 10)); end
            end
        end
        ce = 1'b1; tick = 1'b0; msg_req = 1'b0;
        step();
        checks++; if (disp_word !== exp_win(w16, 10)) begin errors++; $display("FAIL ce_resume got %h exp %h", disp_word, exp_win(w16, 10)); end
        tick_pulse();
        checks++; if (disp_word !== exp_win(w16, 9)) begin errors++; $display("FAIL ce_tick got %h exp %h", disp_word, exp_win(w16, 9)); end
    endtask

    task automatic test_reset_mid_msg();
        msg_req = 1'b1;
        step();
        msg_req = 1'b0;
        checks++; if (src !== 2'b10) begin errors++; $display("FAIL rmsg_enter got %b exp 10", src); end
        ce = 1'b0; sclr = 1'b1;
        step();
        ce = 1'b1; sclr = 1'b0;
        checks++; if (disp_word !== BLANKS || disp_blink !== 6'd0 || src !== 2'b00) begin errors++; $display("FAIL rmsg_reset got %h blink %b src %b exp %h 0 00", disp_word, disp_blink, src, BLANKS); end
        checks++; if (msg_ack !== 1'b0 || scrolling !== 1'b0) begin errors++; $display("FAIL rmsg_flags got ack %b scr %b exp 0 0", msg_ack, scrolling); end
    endtask

    initial begin
        sclr = 1'b1; ce = 1'b1; tick = 1'b0; mode_morse = 1'b0; word_ended = 1'b0;
        msg_req = 1'b0; menu_word = '0; msg_word = '0; menu_blink = '0;
        word = build_word(0); word_len = '0;
        #1;
        test_reset();
        test_menu();
        test_short_word();
        test_scroll();
        test_msg();
        test_msg_zero_ticks();
        test_clamp_and_ce();
        test_reset_mid_msg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
